fp_sum_squares_acc: RTL and testbench
=====================================

Name: fp_sum_squares_acc

Overview:
- Streaming IEEE-754 single-precision sum-of-squares accumulator.
- Produces the squared vector norm (sum of x_i^2) that feeds FloatingSqrt in the cosine-similarity datapath. It is the operand-producing end of the square-root stage.
- Accepts one float element per handshake, squares it, and accumulates it.
- Presents the final sum and element count on an output handshake when the element tagged last has been absorbed.
- Reuses the combinational FloatingMultiplication and FloatingAddition modules, with a 2-stage registered datapath.

Parameters:
XLEN, 32, float word width; only 32 is supported.
CNTW, 16, element-count width.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  element valid
in_ready  output  1  block can accept an element
in_data  input  XLEN  IEEE-754 single element
in_last  input  1  element is the final element of the vector
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  XLEN  sum of squares (sign bit always 0)
out_count  output  CNTW  number of elements accumulated
overflow  output  1  sticky: a product or the sum reached exponent 8'hFF from finite operands; valid with out_valid
exception  output  1  sticky: an input was NaN or Inf; valid with out_valid

Behaviour:
- Reset (rst=1 at clk edge), regardless of state or in-flight data:
  - state=ACCUM; acc=0; count=0; p_valid=0; p_last=0.
  - out_valid=0, out_data=0, out_count=0, overflow=0, exception=0.
  - in_ready=1 from the first cycle after reset.
- in_ready = (state==ACCUM). It is decoded from the registered state and has no combinational path from in_valid or out_ready.
- An element is accepted on a clk edge where in_valid&&in_ready.
- Stage 1, on the edge of acceptance:
  - p_reg <= FloatingMultiplication(in_data,in_data) with bit31 forced to 0.
  - p_valid<=1; p_last<=in_last.
  - exception set if in_data[30:23]==8'hFF.
- Stage 2, on the edge after that, when p_valid:
  - acc <= FloatingAddition(acc,p_reg); count <= count+1, saturating at all-ones.
- Overflow handling:
  - If the product exponent or the sum exponent equals 8'hFF while the input was finite, set overflow and load acc=32'h7F800000.
  - Once overflow is set, acc stays +Inf.
- Exception handling: if exception is set, the final out_data is forced to 32'h7FC00000.
- FSM:
  - ACCUM -> DRAIN on accepting an element with in_last=1. in_ready drops the next cycle.
  - DRAIN: stage 2 absorbs the last product. Then out_data<=final acc, out_count<=final count, out_valid<=1, and the state moves to HOLD.
  - HOLD: out_data, out_count, overflow and exception are held stable while out_valid&&!out_ready.
  - HOLD, on an edge with out_ready=1: out_valid<=0; acc, count, overflow and exception are cleared; the state moves to ACCUM.
- Latency: last element accepted at edge t. Result registered at edge t+2, so out_valid is high in cycle t+2. in_ready is 0 in cycles t+1 and t+2 and until the edge after the out handshake.
- Throughput: one element per cycle in ACCUM. There is no RAW hazard because the adder is combinational into acc within a single cycle.
- Single-element vector (in_last on the first beat) is legal: out_count=1.
- Zero-length vectors do not exist; there is no flush without in_last.
- in_data is ignored when in_valid=0. Inputs offered while in_ready=0 are not consumed and must be held by the source.
- Negative zero squares to +0; denormals go through the multiplier unchanged.

Test Plan:
- Reset then send 3.0 (0x40400000), 4.0 (0x40800000, last) back-to-back, out_ready=1 -> out_valid high exactly 2 cycles after the last accept; out_data=0x41C80000 (25.0), out_count=2, overflow=0, exception=0.
- Single element -2.0 (0xC0000000, last) -> out_data=0x40800000, out_count=1, sign bit 0.
- Send 1.0, 2.0 (last), hold out_ready=0 for 3 cycles -> out_data=0x40A00000 stays stable and in_ready=0 throughout. A source holding in_valid=1 with 5.0 is not consumed until 1 cycle after out_ready=1. The next vector (5.0 last) then yields 0x41C80000, count=1 (accumulator was cleared).
- Send 0x7F000000, then 1.0 (last) -> overflow=1, out_data=0x7F800000, exception=0.
- Send 0x7FC00000 (NaN, last) -> exception=1, out_data=0x7FC00000. The next clean vector 3.0 (last) -> exception=0, out_data=0x41100000.
- Assert rst for 1 cycle after 2 of 4 elements were accepted -> next cycle in_ready=1 and out_valid=0. A fresh vector 4.0 (last) -> out_data=0x41800000, out_count=1.

Source files
------------

// File: rtl/fp_sum_squares_acc.sv
// Streaming float32 sum-of-squares: square each accepted element, accumulate, emit sum+count on last.
// Result is valid two edges after the last accept; input stalls (in_ready=0) until the result handshakes.

module FloatingMultiplication (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  logic               s;
  logic [7:0]         ea, eb, ea_e, eb_e;
  logic [23:0]        ma, mb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]        prod;
  logic [5:0]         msb;
  logic [46:0]        norm;
  logic signed [10:0] e0, e1;
  logic               rnd;
  logic [23:0]        mr;

  always_comb begin
    s      = a_i[31] ^ b_i[31];
    ea     = a_i[30:23];
    eb     = b_i[30:23];
    ea_e   = (ea == 8'd0) ? 8'd1 : ea;
    eb_e   = (eb == 8'd0) ? 8'd1 : eb;
    ma     = {ea != 8'd0, a_i[22:0]};
    mb     = {eb != 8'd0, b_i[22:0]};
    a_nan  = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b_i[22:0] != 23'd0);
    a_inf  = (ea == 8'hFF) && (a_i[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b_i[22:0] == 23'd0);
    a_zero = (ea == 8'd0) && (a_i[22:0] == 23'd0);
    b_zero = (eb == 8'd0) && (b_i[22:0] == 23'd0);
    prod   = 48'(ma) * 48'(mb);
    msb    = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (prod[i]) msb = 6'(i);
    end
    // Leading one is shifted out of bit 46; what remains is the fraction plus guard/sticky bits.
    norm = prod[46:0] << (6'd47 - msb);
    e0   = $signed({3'b000, ea_e}) + $signed({3'b000, eb_e}) + $signed({5'b00000, msb}) - 11'sd173;
    rnd  = norm[23] & ((|norm[22:0]) | norm[24]);
    mr   = {1'b0, norm[46:24]} + {23'd0, rnd};
    e1   = e0 + $signed({10'd0, mr[23]});
    y_o  = {s, e1[7:0], mr[22:0]};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      y_o = 32'h7FC00000;
    end else if (a_inf || b_inf) begin
      y_o = {s, 8'hFF, 23'd0};
    end else if (prod == 48'd0) begin
      y_o = {s, 31'd0};
    end else if (e1 >= 11'sd255) begin
      y_o = {s, 8'hFF, 23'd0};
    end else if (e1 <= 11'sd0) begin
      y_o = {s, 31'd0};
    end
  end
endmodule

module FloatingAddition (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  logic [31:0]       big, sml;
  logic [7:0]        eb_e, es_e, d;
  logic [26:0]       mb, ms, sh;
  logic              st;
  logic [27:0]       sum;
  logic [4:0]        msb;
  logic [26:0]       n;
  logic signed [9:0] e0, e1, e2;
  logic              rnd;
  logic [23:0]       fr;
  logic              a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
    b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
    a_inf = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
    b_inf = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);
    if (a_i[30:0] >= b_i[30:0]) begin
      big = a_i;
      sml = b_i;
    end else begin
      big = b_i;
      sml = a_i;
    end
    eb_e = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    es_e = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mb   = {big[30:23] != 8'd0, big[22:0], 3'b000};
    ms   = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    d    = eb_e - es_e;
    if (d >= 8'd27) begin
      sh = 27'd0;
      st = |ms;
    end else begin
      sh = ms >> d;
      st = |(ms & ~({27{1'b1}} << d));
    end
    if (big[31] == sml[31]) sum = {1'b0, mb} + {1'b0, sh[26:1], sh[0] | st};
    else                    sum = {1'b0, mb} - {1'b0, sh[26:1], sh[0] | st};
    msb = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) msb = 5'(i);
    end
    e0 = $signed({2'b00, eb_e});
    if (sum[27]) begin
      n  = {sum[27:2], sum[1] | sum[0]};
      e1 = e0 + 10'sd1;
    end else begin
      n  = sum[26:0] << (5'd26 - msb);
      e1 = e0 - $signed({5'd0, 5'd26 - msb});
    end
    rnd = n[2] & (n[1] | n[0] | n[3]);
    fr  = {1'b0, n[25:3]} + {23'd0, rnd};
    e2  = e1 + $signed({9'd0, fr[23]});
    y_o = {big[31], e2[7:0], fr[22:0]};
    if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31]))) begin
      y_o = 32'h7FC00000;
    end else if (a_inf) begin
      y_o = a_i;
    end else if (b_inf) begin
      y_o = b_i;
    end else if (!n[26]) begin
      y_o = 32'd0;
    end else if (e2 >= 10'sd255) begin
      y_o = {big[31], 8'hFF, 23'd0};
    end else if (e2 <= 10'sd0) begin
      y_o = {big[31], 31'd0};
    end
  end
endmodule

module fp_sum_squares_acc #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [CNTW-1:0] out_count,
  output logic            overflow,
  output logic            exception
);
  typedef enum logic [1:0] {ACCUM = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] p_q, p_d, acc_q, acc_d, out_dat_q, out_dat_d;
  logic [CNTW-1:0] cnt_q, cnt_d, out_cnt_q, out_cnt_d;
  logic            p_vld_q, p_vld_d, p_last_q, p_last_d, p_fin_q, p_fin_d, p_ovf_q, p_ovf_d;
  logic            ovf_q, ovf_d, exc_q, exc_d, out_vld_q, out_vld_d;
  logic [XLEN-1:0] prod, sum;
  logic            accept, in_fin;

  FloatingMultiplication u_mul (.a_i(in_data), .b_i(in_data), .y_o(prod));
  FloatingAddition       u_add (.a_i(acc_q),   .b_i(p_q),     .y_o(sum));

  assign in_ready  = (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign in_fin    = (in_data[30:23] != 8'hFF);
  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign out_count = out_cnt_q;
  assign overflow  = ovf_q;
  assign exception = exc_q;

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    p_vld_d   = accept;
    p_last_d  = accept && in_last;
    p_fin_d   = p_fin_q;
    p_ovf_d   = p_ovf_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    exc_d     = exc_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_cnt_d = out_cnt_q;

    if (accept) begin
      p_d     = {1'b0, prod[30:0]};
      p_fin_d = in_fin;
      p_ovf_d = in_fin && (prod[30:23] == 8'hFF);
      if (!in_fin) exc_d = 1'b1;
    end

    if (p_vld_q) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);
      // Once saturated to +Inf the accumulator is pinned there, even against later NaN products.
      if (ovf_q) begin
        acc_d = 32'h7F800000;
      end else if (p_ovf_q || (p_fin_q && (acc_q[30:23] != 8'hFF) && (sum[30:23] == 8'hFF))) begin
        ovf_d = 1'b1;
        acc_d = 32'h7F800000;
      end else begin
        acc_d = sum;
      end
    end

    case (state_q)
      ACCUM: begin
        if (accept && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        // The cycle after the last accept the product is still in flight; acc is final one edge later.
        if (!(p_vld_q && p_last_q)) begin
          out_vld_d = 1'b1;
          out_dat_d = exc_q ? 32'h7FC00000 : acc_q;
          out_cnt_d = cnt_q;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_vld_d = 1'b0;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          exc_d     = 1'b0;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      p_q       <= '0;
      p_vld_q   <= 1'b0;
      p_last_q  <= 1'b0;
      p_fin_q   <= 1'b0;
      p_ovf_q   <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      exc_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      p_vld_q   <= p_vld_d;
      p_last_q  <= p_last_d;
      p_fin_q   <= p_fin_d;
      p_ovf_q   <= p_ovf_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      exc_q     <= exc_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_cnt_q <= out_cnt_d;
    end
  end
endmodule

// File: tb/tb_fp_sum_squares_acc.sv
// Bench for fp_sum_squares_acc: expected results queued at stimulus time, popped when out_valid rises.
module tb_fp_sum_squares_acc;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic        overflow, exception;

  typedef struct packed {
    logic [31:0] dat;
    logic [15:0] cnt;
    logic        ovf;
    logic        exc;
  } res_t;

  res_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   t_acc = 0;

  fp_sum_squares_acc #(.XLEN(32), .CNTW(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .overflow(overflow), .exception(exception)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish required=finish");
    $fatal(1);
  end

  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_ready got in_ready=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    t_acc    = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output res_t got, output int lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL out_timeout got out_valid=%b required=1", out_valid);
    end
    got = {out_data, out_count, overflow, exception};
    lat = cyc - t_acc;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    n_vec++;
    if ({out_data, out_count, overflow, exception} !== 50'd0) begin
      n_err++;
      $display("FAIL reset_outputs got data=%h cnt=%0d ovf=%b exc=%b required all zero",
               out_data, out_count, overflow, exception);
    end
  endtask

  task automatic test_back_to_back();
    res_t got, e;
    int   lat;
    out_ready = 1'b1;
    send(32'h40400000, 1'b0);
    send(32'h40800000, 1'b1);
    exp_q.push_back('{dat: 32'h41C80000, cnt: 16'd2, ovf: 1'b0, exc: 1'b0});
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_drop got=%b required=0", in_ready); end
    wait_out(got, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (lat != 2) begin n_err++; $display("FAIL b2b_latency got=%0d required=2", lat); end
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL b2b_result got data=%h cnt=%0d ovf=%b exc=%b required data=%h cnt=%0d ovf=%b exc=%b",
               got.dat, got.cnt, got.ovf, got.exc, e.dat, e.cnt, e.ovf, e.exc);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_at_out got=%b required=0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_after_hs got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    res_t got, e;
    int   lat;
    send(32'hC0000000, 1'b1);
    exp_q.push_back('{dat: 32'h40800000, cnt: 16'd1, ovf: 1'b0, exc: 1'b0});
    wait_out(got, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL single_result got data=%h cnt=%0d required data=%h cnt=%0d", got.dat, got.cnt, e.dat, e.cnt);
    end
    n_vec++;
    if (lat != 2) begin n_err++; $display("FAIL single_latency got=%0d required=2", lat); end
    handshake();
  endtask

  task automatic test_backpressure();
    res_t got, e;
    int   lat;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    exp_q.push_back('{dat: 32'h40A00000, cnt: 16'd2, ovf: 1'b0, exc: 1'b0});
    wait_out(got, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL bp_result got data=%h cnt=%0d required data=%h cnt=%0d", got.dat, got.cnt, e.dat, e.cnt);
    end
    in_valid = 1'b1; in_data = 32'h40A00000; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, in_ready, out_data, out_count} !== {1'b1, 1'b0, 32'h40A00000, 16'd2}) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got out_valid=%b in_ready=%b data=%h cnt=%0d required 1 0 40a00000 2",
                 i, out_valid, in_ready, out_data, out_count);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_release got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    t_acc    = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_q.push_back('{dat: 32'h41C80000, cnt: 16'd1, ovf: 1'b0, exc: 1'b0});
    wait_out(got, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL bp_next_result got data=%h cnt=%0d required data=%h cnt=%0d", got.dat, got.cnt, e.dat, e.cnt);
    end
    n_vec++;
    if (lat != 2) begin n_err++; $display("FAIL bp_next_latency got=%0d required=2", lat); end
    handshake();
  endtask

  task automatic test_overflow();
    res_t got, e;
    int   lat;
    send(32'h7F000000, 1'b0);
    send(32'h3F800000, 1'b1);
    exp_q.push_back('{dat: 32'h7F800000, cnt: 16'd2, ovf: 1'b1, exc: 1'b0});
    wait_out(got, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL ovf_result got data=%h cnt=%0d ovf=%b exc=%b required data=%h cnt=%0d ovf=%b exc=%b",
               got.dat, got.cnt, got.ovf, got.exc, e.dat, e.cnt, e.ovf, e.exc);
    end
    handshake();
  endtask

  task automatic test_exception();
    res_t got, e;
    int   lat;
    send(32'h7FC00000, 1'b1);
    exp_q.push_back('{dat: 32'h7FC00000, cnt: 16'd1, ovf: 1'b0, exc: 1'b1});
    wait_out(got, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL exc_result got data=%h ovf=%b exc=%b required data=%h ovf=%b exc=%b",
               got.dat, got.ovf, got.exc, e.dat, e.ovf, e.exc);
    end
    handshake();
    send(32'h40400000, 1'b1);
    exp_q.push_back('{dat: 32'h41100000, cnt: 16'd1, ovf: 1'b0, exc: 1'b0});
    wait_out(got, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL exc_clear got data=%h exc=%b required data=%h exc=%b", got.dat, got.exc, e.dat, e.exc);
    end
    handshake();
  endtask

  task automatic test_mid_reset();
    res_t got, e;
    int   lat;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL midrst_state got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    n_vec++;
    if ({out_count, overflow, exception} !== 18'd0) begin
      n_err++;
      $display("FAIL midrst_flags got cnt=%0d ovf=%b exc=%b required 0 0 0", out_count, overflow, exception);
    end
    send(32'h40800000, 1'b1);
    exp_q.push_back('{dat: 32'h41800000, cnt: 16'd1, ovf: 1'b0, exc: 1'b0});
    wait_out(got, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL midrst_result got data=%h cnt=%0d required data=%h cnt=%0d", got.dat, got.cnt, e.dat, e.cnt);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_backpressure();
    test_overflow();
    test_exception();
    test_mid_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
